read_return_router: RTL

Return-path counterpart of the arbiter's request data path. The arbiter picks one request out of 16 bank queues (4 groups × 4 banks) and issues it to DRAM. This block records the group/bank/id of every issued read in issue order, then pairs each returning read burst with the oldest outstanding record. It drives the data back to the originating bank queue as a one-hot valid plus shared data/id bus, registered.

---
 rtl/read_return_router.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/read_return_router.sv
// -----------------------------------------------------------------------------
// read_return_router
//
// Return path for DRAM reads. Every read the arbiter issues is recorded as
// {group, bank, id} in issue order. Each returning read beat is paired with the
// oldest outstanding record and routed back to its originating bank queue as a
// registered one-hot valid plus a shared data/id bus.
//
// Optional feature: define RD_RETURN_TIMEOUT_EN to build an age counter on the
// oldest record that raises a sticky timeout_err after TIMEOUT cycles without a
// return. When undefined, no counter is built and timeout_err is tied low.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset (released synchronously)
//   issue_valid  arbiter issued a read this cycle
//   issue_ready  record FIFO has room for an issue
//   issue_group  group index (0..3) of the issued read
//   issue_bank   bank index (0..3) within the group
//   issue_id     request id carried back to the bank queue
//   rd_valid     one beat of read data returning from DRAM
//   rd_data      returned data
//   resp_valid   one-hot response valid, bit = group*4+bank
//   resp_data    routed data (holds when not valid)
//   resp_id      id of routed read (holds when not valid)
//   outstanding  number of records currently held
//   orphan_err   sticky: data returned while no record was held
//   timeout_err  sticky: oldest record waited TIMEOUT cycles (macro only)
// -----------------------------------------------------------------------------
module read_return_router #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [1:0]                 issue_group,
    input  logic [1:0]                 issue_bank,
    input  logic [ID_W-1:0]            issue_id,
    input  logic                       rd_valid,
    input  logic [DATA_W-1:0]          rd_data,
    output logic [15:0]                resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [ID_W-1:0]            resp_id,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       orphan_err,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int REC_W = ID_W + 4;

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("read_return_router: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    // Record storage holds data only, so it carries no reset.
    logic [REC_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [REC_W-1:0] w_head;
    logic [3:0]       w_head_sel;
    logic [ID_W-1:0]  w_head_id;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    // Ready looks only at occupancy, never at a same-cycle pop, so a full
    // FIFO refuses issues even while a return is draining it.
    assign w_push     = issue_valid && !w_full;
    // A record pushed this cycle is not yet counted, so an empty FIFO
    // cannot pair it with a same-cycle return.
    assign w_pop      = rd_valid && !w_empty;
    assign w_head     = r_mem[r_rptr];
    assign w_head_sel = w_head[REC_W-1:ID_W];
    assign w_head_id  = w_head[ID_W-1:0];

    assign issue_ready = !w_full;
    assign outstanding = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {issue_group, issue_bank, issue_id};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            orphan_err <= 1'b0;
        end else begin
            // Pointers are PTR_W bits wide, so wrap modulo DEPTH is natural.
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            resp_valid <= w_pop ? (16'd1 << w_head_sel) : 16'd0;
            if (w_pop) begin
                resp_data <= rd_data;
                resp_id   <= w_head_id;
            end

            if (rd_valid && w_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

`ifdef RD_RETURN_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    logic [AGE_W-1:0] r_age;
    logic             r_timeout_err;

    // Age of the current head record; saturates at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age         <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_pop || w_empty) begin
            r_age <= '0;
        end else if (r_age != AGE_W'(TIMEOUT)) begin
            r_age <= r_age + AGE_W'(1);
            // Flag on the same edge the counter reaches TIMEOUT.
            if (r_age == AGE_W'(TIMEOUT - 1)) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
